// File: rtl/lifo_drain.sv
// Read-side burst engine for the lifo stack: pops up to len_i words and
// streams them most-recent-first on a valid/ready interface.
module lifo_drain #(
  parameter int DWIDTH        = 16,
  parameter int AWIDTH        = 8,
  parameter bit STOP_ON_EMPTY = 1'b1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              start_i,
  input  logic [AWIDTH:0]   len_i,
  output logic              lifo_rdreq_o,
  input  logic [DWIDTH-1:0] lifo_q_i,
  input  logic [AWIDTH:0]   lifo_usedw_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              short_o,
  output logic [AWIDTH:0]   count_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam logic [AWIDTH:0] ONE     = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] CNT_MAX = {1'b1, {AWIDTH{1'b0}}};

  state_t            state;
  logic [AWIDTH:0]   remain;
  logic              inflight;
  logic [1:0]        buf_cnt;
  logic [DWIDTH-1:0] tail;

  logic              xfer;
  logic [1:0]        cnt_eff;
  logic              drained;
  logic              ran_dry;
  logic              last_pop;

  assign valid_o = (buf_cnt != 2'd0);

  // Occupancy net of this cycle's transfer keeps one word per cycle flowing
  // while still bounding buffered + in-flight words to two.
  always_comb begin
    xfer         = valid_o && ready_i;
    cnt_eff      = buf_cnt - {1'b0, xfer};
    lifo_rdreq_o = (state == RUN) && (remain != '0)
                   && (lifo_usedw_i > {{AWIDTH{1'b0}}, inflight})
                   && (({1'b0, inflight} + cnt_eff) < 2'd2);
    drained      = !inflight && (cnt_eff == 2'd0);
    ran_dry      = STOP_ON_EMPTY && (lifo_usedw_i == '0) && !inflight
                   && (remain != '0);
    last_pop     = lifo_rdreq_o && (remain == ONE);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state    <= IDLE;
      remain   <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      data_o   <= '0;
      tail     <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      short_o  <= 1'b0;
      count_o  <= '0;
    end else begin
      inflight <= lifo_rdreq_o;
      if (lifo_rdreq_o)
        remain <= remain - ONE;

      // data_o is the head entry, tail the second; a word arrives one cycle after its pop
      case ({xfer, inflight})
        2'b01: begin
          if (buf_cnt == 2'd0)
            data_o <= lifo_q_i;
          else
            tail <= lifo_q_i;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b10: begin
          data_o  <= tail;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            data_o <= lifo_q_i;
          end else begin
            data_o <= tail;
            tail   <= lifo_q_i;
          end
        end
        default: ;
      endcase

      if (xfer && (count_o != CNT_MAX))
        count_o <= count_o + ONE;

      case (state)
        IDLE: begin
          if (start_i) begin
            remain  <= len_i;
            count_o <= '0;
            short_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= (len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (last_pop) begin
            state <= FLUSH;
          end else if (ran_dry) begin
            short_o <= 1'b1;
            // Nothing left to deliver: finish now rather than idle a cycle in FLUSH
            if (drained) begin
              state  <= DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (drained) begin
            state  <= DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        DONE: begin
          // Zero-length bursts arrive here with done_o low and raise it one cycle later
          if (done_o) begin
            done_o <= 1'b0;
            state  <= IDLE;
          end else begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
